// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter sharing the lot occupancy counters between NUM_GATES gates.
// Optional reject statistics are enabled with the PARKING_REJECT_STATS_EN macro.
module parking_gate_arbiter #(
  parameter int NUM_GATES = 4,
  parameter int TOTAL_CAP = 700,
  parameter int UNI_CAP   = 500
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 day_clear,
  input  logic [NUM_GATES-1:0] req,
  input  logic [NUM_GATES-1:0] is_exit,
  input  logic [NUM_GATES-1:0] is_uni,
  output logic [NUM_GATES-1:0] done,
  output logic                 accepted,
  output logic                 faulty_exit,
  output logic [9:0]           uni_count,
  output logic [9:0]           gen_count,
  output logic                 uni_full,
  output logic                 gen_full,
`ifdef PARKING_REJECT_STATS_EN
  output logic [15:0]          reject_entry_cnt,
  output logic [15:0]          reject_exit_cnt,
`endif
  output logic                 busy
);

  localparam int IDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam logic [9:0] UNI_CAP_C = 10'(UNI_CAP);
  localparam logic [9:0] GEN_CAP_C = 10'(TOTAL_CAP - UNI_CAP);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, win_q, win_d;
  logic                 exit_q, exit_d, uni_q, uni_d;
  logic [9:0]           uni_cnt_q, uni_cnt_d, gen_cnt_q, gen_cnt_d;
  logic [NUM_GATES-1:0] done_q, done_d;
  logic                 acc_q, acc_d, faulty_q, faulty_d;
  logic                 rej_entry_q, rej_entry_d;
  logic [15:0]          rej_ent_cnt_q, rej_ent_cnt_d, rej_ext_cnt_q, rej_ext_cnt_d;

  logic                 found;
  logic [IDX_W-1:0]     pick, cand;
  logic [9:0]           pool_cnt, pool_cap;
  logic                 ok;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    exit_d        = exit_q;
    uni_d         = uni_q;
    uni_cnt_d     = uni_cnt_q;
    gen_cnt_d     = gen_cnt_q;
    done_d        = '0;
    acc_d         = 1'b0;
    faulty_d      = 1'b0;
    rej_entry_d   = 1'b0;
    rej_ent_cnt_d = rej_ent_cnt_q;
    rej_ext_cnt_d = rej_ext_cnt_q;
    found         = 1'b0;
    pick          = ptr_q;
    cand          = ptr_q;

    // Search upward from the pointer, wrapping, so the last winner goes to the back.
    for (int i = 0; i < NUM_GATES; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_GATES);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    pool_cnt = uni_q ? uni_cnt_q : gen_cnt_q;
    pool_cap = uni_q ? UNI_CAP_C : GEN_CAP_C;
    ok       = exit_q ? (pool_cnt != 10'd0) : (pool_cnt < pool_cap);

    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          exit_d  = is_exit[pick];
          uni_d   = is_uni[pick];
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d       = RESP;
        done_d[win_q] = 1'b1;
        if (!day_clear) begin
          acc_d       = ok;
          faulty_d    = exit_q && !ok;
          rej_entry_d = !exit_q && !ok;
          if (ok) begin
            if (uni_q) uni_cnt_d = exit_q ? uni_cnt_q - 10'd1 : uni_cnt_q + 10'd1;
            else       gen_cnt_d = exit_q ? gen_cnt_q - 10'd1 : gen_cnt_q + 10'd1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = (win_q == IDX_W'(NUM_GATES - 1)) ? '0 : win_q + 1'b1;
        if (rej_entry_q && rej_ent_cnt_q != 16'hFFFF) rej_ent_cnt_d = rej_ent_cnt_q + 16'd1;
        if (faulty_q && rej_ext_cnt_q != 16'hFFFF)    rej_ext_cnt_d = rej_ext_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (day_clear) begin
      uni_cnt_d     = '0;
      gen_cnt_d     = '0;
      rej_ent_cnt_d = '0;
      rej_ext_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      exit_q        <= 1'b0;
      uni_q         <= 1'b0;
      uni_cnt_q     <= '0;
      gen_cnt_q     <= '0;
      done_q        <= '0;
      acc_q         <= 1'b0;
      faulty_q      <= 1'b0;
      rej_entry_q   <= 1'b0;
      rej_ent_cnt_q <= '0;
      rej_ext_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      exit_q        <= exit_d;
      uni_q         <= uni_d;
      uni_cnt_q     <= uni_cnt_d;
      gen_cnt_q     <= gen_cnt_d;
      done_q        <= done_d;
      acc_q         <= acc_d;
      faulty_q      <= faulty_d;
      rej_entry_q   <= rej_entry_d;
      rej_ent_cnt_q <= rej_ent_cnt_d;
      rej_ext_cnt_q <= rej_ext_cnt_d;
    end
  end

  // A day_clear landing in RESP cancels the verdict already on the bus.
  assign done        = done_q;
  assign accepted    = acc_q && !day_clear;
  assign faulty_exit = faulty_q && !day_clear;
  assign uni_count   = uni_cnt_q;
  assign gen_count   = gen_cnt_q;
  assign uni_full    = (uni_cnt_q == UNI_CAP_C);
  assign gen_full    = (gen_cnt_q == GEN_CAP_C);
  assign busy        = (state_q != IDLE);

`ifdef PARKING_REJECT_STATS_EN
  assign reject_entry_cnt = rej_ent_cnt_q;
  assign reject_exit_cnt  = rej_ext_cnt_q;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: vector table plus multi-cycle corner sequences.
module tb_parking_gate_arbiter;

  localparam int NG = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          day_clear = 1'b0;
  logic [NG-1:0] req = '0, is_exit = '0, is_uni = '0;
  logic [NG-1:0] done;
  logic          accepted, faulty_exit, uni_full, gen_full, busy;
  logic [9:0]    uni_count, gen_count;
`ifdef PARKING_REJECT_STATS_EN
  logic [15:0]   reject_entry_cnt, reject_exit_cnt;
`endif

  int nchk = 0;
  int nerr = 0;

  parking_gate_arbiter #(.NUM_GATES(NG), .TOTAL_CAP(700), .UNI_CAP(500)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .day_clear   (day_clear),
    .req         (req),
    .is_exit     (is_exit),
    .is_uni      (is_uni),
    .done        (done),
    .accepted    (accepted),
    .faulty_exit (faulty_exit),
    .uni_count   (uni_count),
    .gen_count   (gen_count),
    .uni_full    (uni_full),
    .gen_full    (gen_full),
`ifdef PARKING_REJECT_STATS_EN
    .reject_entry_cnt (reject_entry_cnt),
    .reject_exit_cnt  (reject_exit_cnt),
`endif
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int gate;
    bit ex;
    bit un;
    bit acc;
    bit flt;
    int ucnt;
    int gcnt;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called during an IDLE cycle; returns in the next IDLE cycle with req dropped.
  task automatic do_req(input int g, input bit ex, input bit un, input bit exp_acc, input bit exp_flt);
    req[g]     = 1'b1;
    is_exit[g] = ex;
    is_uni[g]  = un;
    step();
    chk("grant_done_low", int'(done), 0);
    chk("grant_busy", int'(busy), 1);
    step();
    chk("done_onehot", int'(done), 1 << g);
    chk("accepted", int'(accepted), int'(exp_acc));
    chk("faulty_exit", int'(faulty_exit), int'(exp_flt));
    step();
    req[g] = 1'b0;
    chk("done_cleared", int'(done), 0);
  endtask

  initial begin
    vecs[0] = '{gate:0, ex:0, un:1, acc:1, flt:0, ucnt:1, gcnt:0};
    vecs[1] = '{gate:2, ex:1, un:1, acc:1, flt:0, ucnt:0, gcnt:0};
    vecs[2] = '{gate:2, ex:1, un:1, acc:0, flt:1, ucnt:0, gcnt:0};
    vecs[3] = '{gate:1, ex:0, un:0, acc:1, flt:0, ucnt:0, gcnt:1};
    vecs[4] = '{gate:3, ex:1, un:0, acc:1, flt:0, ucnt:0, gcnt:0};
    vecs[5] = '{gate:1, ex:0, un:1, acc:1, flt:0, ucnt:1, gcnt:0};
    vecs[6] = '{gate:3, ex:1, un:0, acc:0, flt:1, ucnt:1, gcnt:0};

    step();
    step();
    chk("rst_done", int'(done), 0);
    chk("rst_accepted", int'(accepted), 0);
    chk("rst_faulty", int'(faulty_exit), 0);
    chk("rst_uni_count", int'(uni_count), 0);
    chk("rst_gen_count", int'(gen_count), 0);
    chk("rst_full", int'({uni_full, gen_full}), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].gate, vecs[i].ex, vecs[i].un, vecs[i].acc, vecs[i].flt);
      chk("vec_uni_count", int'(uni_count), vecs[i].ucnt);
      chk("vec_gen_count", int'(gen_count), vecs[i].gcnt);
    end

    // All four gates request together; pointer is back at 0.
    req = 4'hF; is_exit = '0; is_uni = '0;
    for (int g = 0; g < NG; g++) begin
      step();
      chk("rr_grant_done_low", int'(done), 0);
      step();
      chk("rr_done_order", int'(done), 1 << g);
      chk("rr_accepted", int'(accepted), 1);
      chk("rr_gen_count", int'(gen_count), g + 1);
      step();
      req[g] = 1'b0;
    end
    chk("rr_uni_count", int'(uni_count), 1);

    for (int i = 0; i < 195; i++) do_req(1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("gen_199", int'(gen_count), 199);
    chk("gen_full_199", int'(gen_full), 0);
    do_req(1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("gen_200", int'(gen_count), 200);
    chk("gen_full_200", int'(gen_full), 1);
    for (int i = 0; i < 3; i++) begin
      do_req(1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("gen_stays_200", int'(gen_count), 200);
    end
    do_req(0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("uni_after_gen_full", int'(uni_count), 2);
    chk("uni_full_low", int'(uni_full), 0);

    for (int i = 0; i < 35; i++) do_req(0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("uni_37", int'(uni_count), 37);
`ifdef PARKING_REJECT_STATS_EN
    chk("rej_entry_cnt", int'(reject_entry_cnt), 3);
    chk("rej_exit_cnt", int'(reject_exit_cnt), 2);
`endif

    // day_clear while the request sits in GRANT.
    req[1] = 1'b1; is_exit[1] = 1'b0; is_uni[1] = 1'b1;
    step();
    chk("dc_in_grant_busy", int'(busy), 1);
    day_clear = 1'b1;
    step();
    day_clear = 1'b0;
    chk("dc_grant_done", int'(done), 2);
    chk("dc_grant_accepted", int'(accepted), 0);
    chk("dc_grant_faulty", int'(faulty_exit), 0);
    chk("dc_grant_uni", int'(uni_count), 0);
    chk("dc_grant_gen", int'(gen_count), 0);
    chk("dc_grant_gen_full", int'(gen_full), 0);
`ifdef PARKING_REJECT_STATS_EN
    chk("dc_rej_entry_clr", int'(reject_entry_cnt), 0);
    chk("dc_rej_exit_clr", int'(reject_exit_cnt), 0);
`endif
    step();
    req[1] = 1'b0;

    // day_clear while the verdict is on the bus in RESP.
    req[2] = 1'b1; is_exit[2] = 1'b0; is_uni[2] = 1'b1;
    step();
    step();
    chk("dc_resp_uni_pre", int'(uni_count), 1);
    day_clear = 1'b1;
    #1;
    chk("dc_resp_done", int'(done), 4);
    chk("dc_resp_accepted", int'(accepted), 0);
    step();
    day_clear = 1'b0;
    req[2] = 1'b0;
    chk("dc_resp_uni_post", int'(uni_count), 0);
    chk("dc_resp_busy", int'(busy), 0);

    // Reset in the middle of a transaction: no done may follow.
    req[0] = 1'b1; is_exit[0] = 1'b0; is_uni[0] = 1'b1;
    step();
    chk("mid_rst_busy_pre", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    req[0] = 1'b0;
    step();
    chk("mid_rst_done_hold", int'(done), 0);
    reset_n = 1'b1;
    step();
    step();
    chk("post_rst_done", int'(done), 0);
    chk("post_rst_uni", int'(uni_count), 0);
    chk("post_rst_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
